// File: rtl/ex_stage_mc.sv
// ex_stage_mc: registered execute stage with valid/ready handshakes, flush and an
// optional iterative multiplier (compiled in when EX_MUL_EN is defined).
// One output register; while it holds an untaken result the stage backpressures.
//
// state | meaning
// IDLE  | ready for a new instruction (or holding a result)
// MUL   | multiplier iterating, MUL_STEP bits of Rm per cycle
// WB    | product ready, waiting for the output slot to free
module ex_stage_mc #(
   parameter int WIDTH    = 32,
   parameter int MUL_STEP = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       EXE_CMD,
   input  logic             mul,
   input  logic [3:0]       SR_In,
   input  logic             MEM_R_EN,
   input  logic             MEM_W_EN,
   input  logic [WIDTH-1:0] PC,
   input  logic [WIDTH-1:0] Val_Rn,
   input  logic [WIDTH-1:0] Val_Rm,
   input  logic [11:0]      Shift_operand,
   input  logic             imm,
   input  logic [23:0]      Signed_EX_imm_24,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALU_Result,
   output logic [WIDTH-1:0] Branch_Address,
   output logic [3:0]       SR_Out,
   output logic             MEM_R_EN_out,
   output logic             MEM_W_EN_out,
   output logic [WIDTH-1:0] Store_Data,
   output logic             busy
);

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;

   logic [WIDTH-1:0]  val2;
   logic [WIDTH-1:0]  imm_word;
   logic [4:0]        sh_amt;
   logic [WIDTH:0]    sum;
   logic [WIDTH-1:0]  alu_res;
   logic              alu_c;
   logic              alu_v;
   logic [WIDTH+25:0] br_wide;
   logic [WIDTH-1:0]  branch;
   logic              slot_free;
   logic              accept;
   logic              load_alu;
   logic              load_mul;
   logic [WIDTH-1:0]  ld_res;
   logic [WIDTH-1:0]  ld_br;
   logic [WIDTH-1:0]  ld_sd;
   logic [3:0]        ld_sr;
   logic              ld_r;
   logic              ld_w;
   logic              unused_bits;

   // Rotate right; amounts wrap modulo WIDTH so narrow datapaths stay well defined.
   function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input logic [4:0] amt);
      logic [2*WIDTH-1:0] dbl;
      int a;
      a   = int'(amt) % WIDTH;
      dbl = {x, x} >> a;
      return dbl[WIDTH-1:0];
   endfunction

   assign sh_amt    = Shift_operand[11:7];
   assign slot_free = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;

   // Second operand: memory offset, rotated immediate or shifted register
   always_comb begin
      imm_word = {{(WIDTH-8){1'b0}}, Shift_operand[7:0]};
      val2     = Val_Rm;
      if (MEM_R_EN || MEM_W_EN) begin
         val2 = {{(WIDTH-12){1'b0}}, Shift_operand};
      end else if (imm) begin
         val2 = rotr(imm_word, {Shift_operand[11:8], 1'b0});
      end else begin
         case (Shift_operand[6:5])
            2'b00:   val2 = Val_Rm << sh_amt;
            2'b01:   val2 = Val_Rm >> sh_amt;
            2'b10:   val2 = $signed(Val_Rm) >>> sh_amt;
            default: val2 = rotr(Val_Rm, sh_amt);
         endcase
      end
   end

   // ALU; subtraction is done as Rn + ~Val2 + cin so C means "no borrow"
   always_comb begin
      sum     = '0;
      alu_res = '0;
      alu_c   = SR_In[1];
      alu_v   = SR_In[0];
      case (EXE_CMD)
         CMD_MOV: alu_res = val2;
         CMD_MVN: alu_res = ~val2;
         CMD_ADD, CMD_ADC: begin
            sum     = {1'b0, Val_Rn} + {1'b0, val2}
                      + {{WIDTH{1'b0}}, (EXE_CMD == CMD_ADC) & SR_In[1]};
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (Val_Rn[WIDTH-1] == val2[WIDTH-1]) && (alu_res[WIDTH-1] != Val_Rn[WIDTH-1]);
         end
         CMD_SUB, CMD_SBC: begin
            sum     = {1'b0, Val_Rn} + {1'b0, ~val2}
                      + {{WIDTH{1'b0}}, (EXE_CMD == CMD_SUB) | SR_In[1]};
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (Val_Rn[WIDTH-1] != val2[WIDTH-1]) && (alu_res[WIDTH-1] != Val_Rn[WIDTH-1]);
         end
         CMD_AND: alu_res = Val_Rn & val2;
         CMD_ORR: alu_res = Val_Rn | val2;
         CMD_EOR: alu_res = Val_Rn ^ val2;
         default: alu_res = '0;
      endcase
   end

   assign br_wide = {{(WIDTH+2){Signed_EX_imm_24[23]}}, Signed_EX_imm_24} << 2;
   assign branch  = PC + br_wide[WIDTH-1:0];

`ifdef EX_MUL_EN
   localparam int N  = WIDTH / MUL_STEP;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, MUL, WB} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] partial;
   logic [WIDTH-1:0] mul_br;
   logic [WIDTH-1:0] mul_rm;
   logic [1:0]       mul_cv;

   assign busy        = (state != IDLE);
   assign in_ready    = !busy && !flush && slot_free;
   assign load_alu    = accept && !mul;
   assign load_mul    = (state == WB) && slot_free && !flush;
   assign partial     = mcand * WIDTH'(mplier[MUL_STEP-1:0]);
   assign unused_bits = ^{SR_In[3:2], br_wide[WIDTH+25:WIDTH]};

   // State register
   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state; flush always returns to IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && mul) state_nxt = MUL;
         MUL:     if (cnt == CW'(1)) state_nxt = WB;
         WB:      if (slot_free) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   // Shift-and-add multiplier with side fields captured at accept
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         mul_br <= '0;
         mul_rm <= '0;
         mul_cv <= '0;
      end else if (accept && mul) begin
         cnt    <= CW'(N);
         acc    <= '0;
         mcand  <= Val_Rn;
         mplier <= Val_Rm;
         mul_br <= branch;
         mul_rm <= Val_Rm;
         mul_cv <= SR_In[1:0];
      end else if (state == MUL) begin
         acc    <= acc + partial;
         mcand  <= mcand << MUL_STEP;
         mplier <= mplier >> MUL_STEP;
         cnt    <= cnt - CW'(1);
      end
   end
`else
   assign busy        = 1'b0;
   assign in_ready    = !flush && slot_free;
   assign load_alu    = accept;
   assign load_mul    = 1'b0;
   assign unused_bits = ^{mul, SR_In[3:2], br_wide[WIDTH+25:WIDTH]};
`endif

   // Values to load into the output register: ALU path, or the product in WB
   always_comb begin
      ld_res = alu_res;
      ld_sr  = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
      ld_br  = branch;
      ld_r   = MEM_R_EN;
      ld_w   = MEM_W_EN;
      ld_sd  = Val_Rm;
`ifdef EX_MUL_EN
      if (state == WB) begin
         ld_res = acc;
         ld_sr  = {acc[WIDTH-1], (acc == '0), mul_cv};
         ld_br  = mul_br;
         ld_r   = 1'b0;
         ld_w   = 1'b0;
         ld_sd  = mul_rm;
      end
`endif
   end

   // Output register; flush only drops valid, data stays put
   always_ff @(posedge CLK) begin
      if (RST) begin
         out_valid      <= 1'b0;
         ALU_Result     <= '0;
         Branch_Address <= '0;
         SR_Out         <= '0;
         MEM_R_EN_out   <= 1'b0;
         MEM_W_EN_out   <= 1'b0;
         Store_Data     <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load_alu || load_mul) begin
         out_valid      <= 1'b1;
         ALU_Result     <= ld_res;
         Branch_Address <= ld_br;
         SR_Out         <= ld_sr;
         MEM_R_EN_out   <= ld_r;
         MEM_W_EN_out   <= ld_w;
         Store_Data     <= ld_sd;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed bench for ex_stage_mc: expected results are queued at issue time and
// popped when the stage presents a result.
module tb_ex_stage_mc;

   localparam logic [3:0] MOV = 4'b0001, MVN = 4'b1001, ADD = 4'b0010, ADC = 4'b0011;
   localparam logic [3:0] SUB = 4'b0100, AND = 4'b0110, ORR = 4'b0111, EOR = 4'b1000;

   logic        CLK = 1'b0;
   logic        RST, flush, in_valid, in_ready, mul, MEM_R_EN, MEM_W_EN, imm;
   logic [3:0]  EXE_CMD, SR_In, SR_Out;
   logic [31:0] PC, Val_Rn, Val_Rm, ALU_Result, Branch_Address, Store_Data;
   logic [11:0] Shift_operand;
   logic [23:0] Signed_EX_imm_24;
   logic        out_valid, out_ready, MEM_R_EN_out, MEM_W_EN_out, busy;

   typedef struct {
      logic [3:0]  cmd;
      logic        m;
      logic [3:0]  sr;
      logic        r;
      logic        w;
      logic [31:0] pc;
      logic [31:0] rn;
      logic [31:0] rm;
      logic [11:0] shop;
      logic        im;
      logic [23:0] off;
   } op_t;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  sr;
      logic [31:0] sd;
      logic [31:0] br;
      logic        r;
      logic        w;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   ex_stage_mc #(.WIDTH(32), .MUL_STEP(1)) dut (
      .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .EXE_CMD(EXE_CMD), .mul(mul), .SR_In(SR_In), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
      .PC(PC), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .Shift_operand(Shift_operand), .imm(imm),
      .Signed_EX_imm_24(Signed_EX_imm_24), .out_valid(out_valid), .out_ready(out_ready),
      .ALU_Result(ALU_Result), .Branch_Address(Branch_Address), .SR_Out(SR_Out),
      .MEM_R_EN_out(MEM_R_EN_out), .MEM_W_EN_out(MEM_W_EN_out), .Store_Data(Store_Data),
      .busy(busy)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic op_t mkop(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                                input logic [11:0] shop, input logic im, input logic [3:0] sr = 4'b0,
                                input logic [31:0] pc = 32'h0, input logic [23:0] off = 24'h0,
                                input logic r = 1'b0, input logic w = 1'b0, input logic m = 1'b0);
      op_t o;
      o.cmd = cmd; o.rn = rn; o.rm = rm; o.shop = shop; o.im = im; o.sr = sr;
      o.pc = pc; o.off = off; o.r = r; o.w = w; o.m = m;
      return o;
   endfunction

   function automatic exp_t mkexp(input logic [31:0] res, input logic [3:0] sr, input logic [31:0] sd,
                                  input logic [31:0] br = 32'h0, input logic r = 1'b0,
                                  input logic w = 1'b0);
      exp_t e;
      e.res = res; e.sr = sr; e.sd = sd; e.br = br; e.r = r; e.w = w;
      return e;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input op_t o);
      EXE_CMD = o.cmd; mul = o.m; SR_In = o.sr; MEM_R_EN = o.r; MEM_W_EN = o.w;
      PC = o.pc; Val_Rn = o.rn; Val_Rm = o.rm; Shift_operand = o.shop; imm = o.im;
      Signed_EX_imm_24 = o.off;
   endtask

   // Present one instruction for one cycle; it must be accepted
   task automatic issue(input string tag, input op_t o, input exp_t e, input logic push);
      @(negedge CLK);
      drive(o);
      in_valid = 1'b1;
      if (push) sb.push_back(e);
      #1 check({tag, "_in_ready"}, in_ready, 1'b1);
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
      mul      = 1'b0;
   endtask

   // Wait (bounded) for a result and compare it with the oldest expectation
   task automatic expect_out(input string tag, input int budget);
      exp_t e;
      int   n;
      n = 0;
      while (out_valid !== 1'b1 && n < budget) begin
         @(posedge CLK);
         #1;
         n++;
      end
      if (out_valid !== 1'b1) check({tag, "_timeout"}, out_valid, 1'b1);
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 0, 1);
      end else begin
         e = sb.pop_front();
         check({tag, "_res"}, ALU_Result, e.res);
         check({tag, "_sr"}, SR_Out, e.sr);
         check({tag, "_br"}, Branch_Address, e.br);
         check({tag, "_sd"}, Store_Data, e.sd);
         check({tag, "_men"}, {MEM_R_EN_out, MEM_W_EN_out}, {e.r, e.w});
      end
   endtask

   initial begin
      int busy_cycles;
      int bad_ready;
      int n;
      RST = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      drive(mkop(4'b0, 32'h0, 32'h0, 12'h0, 1'b0));
      repeat (3) @(posedge CLK);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_res", ALU_Result, 32'h0);
      check("rst_br", Branch_Address, 32'h0);
      check("rst_sr", SR_Out, 4'h0);
      check("rst_sd", Store_Data, 32'h0);
      check("rst_men", {MEM_R_EN_out, MEM_W_EN_out}, 2'b00);
      @(negedge CLK);
      RST = 1'b0;
      #1 check("rst_in_ready", in_ready, 1'b1);

      // Back-to-back single-cycle ops, one result per cycle
      issue("add_imm", mkop(ADD, 32'd5, 32'h77, 12'h003, 1'b1), mkexp(32'd8, 4'b0000, 32'h77), 1'b1);
      expect_out("add_imm", 0);
      issue("sub_eq", mkop(SUB, 32'd3, 32'd3, 12'h000, 1'b0), mkexp(32'd0, 4'b0110, 32'd3), 1'b1);
      expect_out("sub_eq", 0);
      issue("branch", mkop(MOV, 32'h0, 32'h12, 12'h000, 1'b1, 4'b0011, 32'h100, 24'hFFFFFE),
            mkexp(32'h0, 4'b0111, 32'h12, 32'hF8), 1'b1);
      expect_out("branch", 0);
      issue("mvn", mkop(MVN, 32'h0, 32'h0, 12'h000, 1'b1), mkexp(32'hFFFF_FFFF, 4'b1000, 32'h0), 1'b1);
      expect_out("mvn", 0);
      issue("add_ovf", mkop(ADD, 32'h7FFF_FFFF, 32'h1, 12'h000, 1'b0),
            mkexp(32'h8000_0000, 4'b1001, 32'h1), 1'b1);
      expect_out("add_ovf", 0);
      issue("add_carry", mkop(ADD, 32'hFFFF_FFFF, 32'h0, 12'h001, 1'b1), mkexp(32'h0, 4'b0110, 32'h0), 1'b1);
      expect_out("add_carry", 0);
      issue("adc", mkop(ADC, 32'h1, 32'h0, 12'h001, 1'b1, 4'b0010), mkexp(32'd3, 4'b0000, 32'h0), 1'b1);
      expect_out("adc", 0);
      issue("sub_borrow", mkop(SUB, 32'h0, 32'h0, 12'h001, 1'b1), mkexp(32'hFFFF_FFFF, 4'b1000, 32'h0), 1'b1);
      expect_out("sub_borrow", 0);
      issue("lsl4", mkop(MOV, 32'h0, 32'h8000_001A, 12'h200, 1'b0), mkexp(32'h0000_01A0, 4'b0000, 32'h8000_001A), 1'b1);
      expect_out("lsl4", 0);
      issue("lsr4", mkop(MOV, 32'h0, 32'h8000_001A, 12'h220, 1'b0), mkexp(32'h0800_0001, 4'b0000, 32'h8000_001A), 1'b1);
      expect_out("lsr4", 0);
      issue("asr4", mkop(MOV, 32'h0, 32'h8000_001A, 12'h240, 1'b0), mkexp(32'hF800_0001, 4'b1000, 32'h8000_001A), 1'b1);
      expect_out("asr4", 0);
      issue("ror4", mkop(MOV, 32'h0, 32'h8000_001A, 12'h260, 1'b0), mkexp(32'hA800_0001, 4'b1000, 32'h8000_001A), 1'b1);
      expect_out("ror4", 0);
      issue("imm_rot", mkop(MOV, 32'h0, 32'h0, 12'h4FF, 1'b1), mkexp(32'hFF00_0000, 4'b1000, 32'h0), 1'b1);
      expect_out("imm_rot", 0);
      issue("load", mkop(ADD, 32'h1000, 32'h55, 12'hABC, 1'b0, 4'b0, 32'h0, 24'h0, 1'b1, 1'b0),
            mkexp(32'h1ABC, 4'b0000, 32'h55, 32'h0, 1'b1, 1'b0), 1'b1);
      expect_out("load", 0);
      issue("store", mkop(ADD, 32'h2000, 32'h66, 12'h004, 1'b0, 4'b0, 32'h0, 24'h0, 1'b0, 1'b1),
            mkexp(32'h2004, 4'b0000, 32'h66, 32'h0, 1'b0, 1'b1), 1'b1);
      expect_out("store", 0);
      issue("and", mkop(AND, 32'hF0F0, 32'hFF00, 12'h000, 1'b0, 4'b0001), mkexp(32'hF000, 4'b0001, 32'hFF00), 1'b1);
      expect_out("and", 0);
      issue("orr", mkop(ORR, 32'hF0F0, 32'hFF00, 12'h000, 1'b0, 4'b0001), mkexp(32'hFFF0, 4'b0001, 32'hFF00), 1'b1);
      expect_out("orr", 0);
      issue("eor", mkop(EOR, 32'hF0F0, 32'hFF00, 12'h000, 1'b0, 4'b0001), mkexp(32'h0FF0, 4'b0001, 32'hFF00), 1'b1);
      expect_out("eor", 0);
      @(posedge CLK);
      #1 check("drain_out_valid", out_valid, 1'b0);

      // Backpressure: result held stable, no accept while the slot is full
      out_ready = 1'b0;
      issue("stall_add", mkop(ADD, 32'd5, 32'd9, 12'h003, 1'b1, 4'b0, 32'h40, 24'h1),
            mkexp(32'd8, 4'b0000, 32'd9, 32'h44), 1'b1);
      expect_out("stall_add", 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         drive(mkop(MOV, 32'h0, 32'h0, 12'h055, 1'b1));
         in_valid = 1'b1;
         #1 check("stall_in_ready", in_ready, 1'b0);
         @(posedge CLK);
         #1;
         check("stall_out_valid", out_valid, 1'b1);
         check("stall_res", ALU_Result, 32'd8);
         check("stall_br", Branch_Address, 32'h44);
      end
      @(negedge CLK);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1 check("release_in_ready", in_ready, 1'b1);
      @(posedge CLK);
      #1;
      check("release_out_valid", out_valid, 1'b0);
      check("release_in_ready_after", in_ready, 1'b1);

      // Flush drops the held result and a coincident input, data stays
      out_ready = 1'b0;
      issue("pre_flush", mkop(ADD, 32'h10, 32'h0, 12'h020, 1'b1), mkexp(32'h30, 4'b0000, 32'h0), 1'b1);
      expect_out("pre_flush", 0);
      @(negedge CLK);
      flush     = 1'b1;
      out_ready = 1'b1;
      drive(mkop(MOV, 32'h0, 32'h0, 12'h055, 1'b1));
      in_valid  = 1'b1;
      #1 check("flush_in_ready", in_ready, 1'b0);
      @(posedge CLK);
      #1;
      check("flush_out_valid", out_valid, 1'b0);
      check("flush_res_kept", ALU_Result, 32'h30);
      flush    = 1'b0;
      in_valid = 1'b0;
      @(posedge CLK);
      #1 check("flush_no_accept", out_valid, 1'b0);
      issue("post_flush", mkop(ADD, 32'd7, 32'h0, 12'h001, 1'b1), mkexp(32'd8, 4'b0000, 32'h0), 1'b1);
      expect_out("post_flush", 0);

`ifdef EX_MUL_EN
      // Iterative multiply: 33 busy cycles with in_ready low
      issue("mul_big", mkop(ADD, 32'h0000_FFFF, 32'h0001_0001, 12'h000, 1'b0, 4'b0010, 32'h200, 24'h4,
                            1'b0, 1'b0, 1'b1),
            mkexp(32'hFFFF_FFFF, 4'b1010, 32'h0001_0001, 32'h210), 1'b1);
      busy_cycles = 0;
      bad_ready   = 0;
      n           = 0;
      while (out_valid !== 1'b1 && n < 100) begin
         if (busy === 1'b1) busy_cycles++;
         if (in_ready !== 1'b0) bad_ready++;
         @(posedge CLK);
         #1;
         n++;
      end
      check("mul_busy_cycles", busy_cycles, 33);
      check("mul_in_ready_low", bad_ready, 0);
      check("mul_busy_done", busy, 1'b0);
      expect_out("mul_big", 0);
      issue("mul_small", mkop(ADD, 32'd123, 32'd456, 12'h000, 1'b0, 4'b0001, 32'h0, 24'h0, 1'b0, 1'b0, 1'b1),
            mkexp(32'h0000_DB18, 4'b0001, 32'd456), 1'b1);
      expect_out("mul_small", 64);
      issue("mul_flush", mkop(ADD, 32'd3, 32'd5, 12'h000, 1'b0, 4'b0, 32'h0, 24'h0, 1'b0, 1'b0, 1'b1),
            mkexp(32'h0, 4'b0, 32'h0), 1'b0);
      repeat (9) @(negedge CLK);
      check("mul_flush_busy_before", busy, 1'b1);
      flush = 1'b1;
      @(posedge CLK);
      #1;
      check("mul_flush_busy", busy, 1'b0);
      check("mul_flush_out_valid", out_valid, 1'b0);
      flush = 1'b0;
      issue("after_mul_flush", mkop(ADD, 32'd1, 32'h0, 12'h001, 1'b1), mkexp(32'd2, 4'b0000, 32'h0), 1'b1);
      expect_out("after_mul_flush", 0);
`else
      // Without the multiplier, mul is ignored and the op completes in one cycle
      issue("mul_ignored", mkop(ADD, 32'd2, 32'h0, 12'h003, 1'b1, 4'b0, 32'h0, 24'h0, 1'b0, 1'b0, 1'b1),
            mkexp(32'd5, 4'b0000, 32'h0), 1'b1);
      check("mul_ignored_busy", busy, 1'b0);
      expect_out("mul_ignored", 0);
      busy_cycles = 0;
      bad_ready   = 0;
      n           = 0;
`endif
      @(posedge CLK);
      #1 check("final_out_valid", out_valid, 1'b0);
      check("final_sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
